// File: rtl/read_slave.sv
// read_slave: AXI3-style read-only slave in front of a word-addressed memory.
// One outstanding burst at a time: the AR channel is accepted in IDLE and the
// burst is then streamed on the R channel in DATA. A backdoor write port fills
// the memory. RDATA is registered, so the first beat appears one cycle after
// the AR handshake.
module read_slave #(
  parameter int BusWidth = 32,
  parameter int tagbits  = 1,
  parameter int AddrBits = 8
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  // backdoor write port
  input  logic                mem_we,
  input  logic [AddrBits-1:0] mem_waddr,
  input  logic [BusWidth-1:0] mem_wdata,
  // AR channel
  input  logic [tagbits-1:0]  ARID,
  input  logic [BusWidth-1:0] ARADDR,
  input  logic [3:0]          ARLEN,
  input  logic [1:0]          ARSIZE,
  input  logic [1:0]          ARBURST,
  input  logic [1:0]          ARLOCK,
  input  logic [3:0]          ARCACHE,
  input  logic [2:0]          ARPROT,
  input  logic                ARVALID,
  output logic                ARREADY,
  // R channel
  output logic [tagbits-1:0]  RID,
  output logic [BusWidth-1:0] RDATA,
  output logic [1:0]          RRESP,
  output logic                RLAST,
  output logic                RVALID,
  input  logic                RREADY
);

  localparam int Words = 2 ** AddrBits;

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] BurstWrap  = 2'b10;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;
  localparam logic [1:0] RespDecerr = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    DATA = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [BusWidth-1:0] mem [Words];

  // FSM and ready-enable
  state_e state_q, state_d;
  logic   arready_en_q;

  // Latched request and burst progress
  logic [tagbits-1:0]  rid_q,    rid_d;
  logic [BusWidth-1:0] addr_q,   addr_d;
  logic [3:0]          len_q,    len_d;
  logic [1:0]          size_q,   size_d;
  logic [1:0]          burst_q,  burst_d;
  logic                slverr_q, slverr_d;
  logic [3:0]          cnt_q,    cnt_d;

  // Registered R payload
  logic [BusWidth-1:0] rdata_q,  rdata_d;
  logic [1:0]          rresp_q,  rresp_d;

  // Handshakes and beat bookkeeping
  logic ar_hs;
  logic r_hs;
  logic last_beat;

  // Address generation
  logic [BusWidth-1:0] addr_inc;
  logic [BusWidth-1:0] incr_addr;
  logic [BusWidth-1:0] wrap_mask;
  logic [BusWidth-1:0] wrap_addr;
  logic [BusWidth-1:0] next_addr;

  // Beat load path
  logic                ar_slverr;
  logic [BusWidth-1:0] load_addr;
  logic                load_slverr;
  logic                load_decerr;
  logic [1:0]          load_resp;
  logic [BusWidth-1:0] load_data;

  // Lock, cache and protection attributes carry no meaning for this slave.
  logic unused_attr;
  assign unused_attr = ^{ARLOCK, ARCACHE, ARPROT};

  // ARREADY is gated by arready_en_q so it stays low during reset and rises at
  // the first edge after release; an R handshake only exists in DATA.
  assign ar_hs     = ARVALID && (state_q == IDLE) && arready_en_q;
  assign r_hs      = RREADY && (state_q == DATA);
  assign last_beat = (cnt_q == len_q);

  // ---------------------------------------------------------------------------
  // Backdoor memory write
  // ---------------------------------------------------------------------------
  // Backdoor write port; a beat load on the same edge still sees the old word.
  // NOTE: the memory array has no reset branch on purpose -- clearing every
  // word would turn the array into a huge bank of resettable flops.
  always_ff @(posedge ACLK) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // State register plus the enable that holds ARREADY low until reset releases.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register, regardless of order.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q      <= IDLE;
      arready_en_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      arready_en_q <= 1'b1;
    end
  end

  // Next-state decode and channel handshake outputs.
  // NOTE: every output of a combinational block gets a default first; a path
  // that skips an assignment would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    ARREADY = 1'b0;
    RVALID  = 1'b0;
    RLAST   = 1'b0;
    unique case (state_q)
      IDLE: begin
        ARREADY = arready_en_q;
        if (ar_hs) begin
          state_d = DATA;
        end
      end
      DATA: begin
        RVALID = 1'b1;
        RLAST  = last_beat;
        if (r_hs && last_beat) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Address generation and beat load
  // ---------------------------------------------------------------------------
  // Next beat address for the latched burst type. WRAP keeps the bits above
  // the container size and lets the low bits roll over inside the container;
  // the container is only a power of two for legal WRAP lengths, and illegal
  // ones are answered with SLVERR so their addresses never reach the memory.
  always_comb begin
    addr_inc  = BusWidth'(1) << size_q;
    incr_addr = addr_q + addr_inc;
    wrap_mask = ((BusWidth'(len_q) + BusWidth'(1)) << size_q) - BusWidth'(1);
    wrap_addr = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
    unique case (burst_q)
      BurstFixed: next_addr = addr_q;
      BurstIncr:  next_addr = incr_addr;
      BurstWrap:  next_addr = wrap_addr;
      default:    next_addr = incr_addr;
    endcase
  end

  // Whole-burst protocol error: reserved burst type or WRAP of illegal length.
  always_comb begin
    ar_slverr = 1'b0;
    if (ARBURST == 2'b11) begin
      ar_slverr = 1'b1;
    end else if (ARBURST == BurstWrap) begin
      ar_slverr = !(ARLEN inside {4'd1, 4'd3, 4'd7, 4'd15});
    end
  end

  // Beat being loaded this edge: the request itself on AR, else the next beat.
  // Words past the memory decode as DECERR; any error beat carries zero data.
  always_comb begin
    load_addr   = ar_hs ? ARADDR : next_addr;
    load_slverr = ar_hs ? ar_slverr : slverr_q;
    load_decerr = (load_addr[BusWidth-1:AddrBits+2] != '0);
    if (load_slverr) begin
      load_resp = RespSlverr;
    end else if (load_decerr) begin
      load_resp = RespDecerr;
    end else begin
      load_resp = RespOkay;
    end
    load_data = (load_resp == RespOkay) ? mem[load_addr[AddrBits+1:2]] : '0;
  end

  // Next-state of the request latches, beat counter and R payload.
  always_comb begin
    rid_d    = rid_q;
    addr_d   = addr_q;
    len_d    = len_q;
    size_d   = size_q;
    burst_d  = burst_q;
    slverr_d = slverr_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (ar_hs) begin
      rid_d    = ARID;
      addr_d   = ARADDR;
      len_d    = ARLEN;
      size_d   = ARSIZE;
      burst_d  = ARBURST;
      slverr_d = ar_slverr;
      cnt_d    = '0;
      rdata_d  = load_data;
      rresp_d  = load_resp;
    end else if (r_hs) begin
      cnt_d = cnt_q + 4'd1;
      if (!last_beat) begin
        addr_d  = next_addr;
        rdata_d = load_data;
        rresp_d = load_resp;
      end
    end
  end

  // Request latches, beat counter and registered R payload.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rid_q    <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      slverr_q <= 1'b0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      rresp_q  <= RespOkay;
    end else begin
      rid_q    <= rid_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      size_q   <= size_d;
      burst_q  <= burst_d;
      slverr_q <= slverr_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end
  end

  assign RID   = rid_q;
  assign RDATA = rdata_q;
  assign RRESP = rresp_q;

endmodule

// File: doc/read_slave.md
READ_SLAVE -- requirements
Module: read_slave

Interface
REQ-001 SHALL have parameter BusWidth, default 32: data and address width in bits.
REQ-002 SHALL have parameter tagbits, default 1: ID width in bits.
REQ-003 SHALL have parameter AddrBits, default 8: word-address width; internal memory holds 2**AddrBits words of BusWidth bits.
REQ-004 SHALL have ports: ACLK  in  1  clock, all logic on rising edge; reset ARESETn, asynchronous, active-low.
REQ-005 SHALL have ports: mem_we  in  1  backdoor write enable; mem_waddr  in  AddrBits  word address; mem_wdata  in  BusWidth  write data.
REQ-006 SHALL have AR inputs: ARID  tagbits; ARADDR  BusWidth, byte address; ARLEN  4, beats minus 1; ARSIZE  2, bytes = 1<<ARSIZE; ARBURST  2, 00 FIXED / 01 INCR / 10 WRAP / 11 reserved; ARLOCK  2; ARCACHE  4; ARPROT  3; ARVALID  1.
REQ-007 SHALL have output ARREADY  1: slave accepts the AR request.
REQ-008 SHALL have R outputs: RID  tagbits; RDATA  BusWidth; RRESP  2; RLAST  1; RVALID  1; and input RREADY  1.

Function
REQ-009 SHALL implement FSM states IDLE and DATA; ARREADY = 1 only in IDLE, RVALID = 1 only in DATA.
REQ-010 AR handshake = ARVALID & ARREADY at a rising edge; SHALL latch ARID, ARADDR, ARLEN, ARSIZE, ARBURST there and move to DATA; ARLOCK/ARCACHE/ARPROT are accepted and ignored.
REQ-011 First beat: RVALID SHALL be 1 in the cycle immediately after the AR handshake edge (latency 1).
REQ-012 RDATA SHALL be a register loaded from mem[beat_addr[AddrBits+1:2]] at the AR handshake edge (first beat) and at each non-last R handshake edge (next beat); it stays stable while RVALID & !RREADY.
REQ-013 RID SHALL equal the latched ARID for every beat; RLAST = 1 only on beat ARLEN (0-based); the burst is exactly ARLEN+1 beats.
REQ-014 Beat address, FIXED: constant ARADDR.
REQ-015 Beat address, INCR: previous + (1<<ARSIZE), BusWidth-bit wrap-around on overflow.
REQ-016 Beat address, WRAP: container = (ARLEN+1)*(1<<ARSIZE) bytes aligned down from ARADDR; next = previous + (1<<ARSIZE), returning to container base when it reaches base+container.
REQ-017 RRESP SHALL be SLVERR (10) for the whole burst if ARBURST = 11, or if WRAP with ARLEN not in {1,3,7,15}.
REQ-018 RRESP SHALL be DECERR (11) for a beat whose address bits above AddrBits+1 are nonzero; otherwise OKAY (00).
REQ-019 On any non-OKAY beat RDATA SHALL be 0; the burst still runs its full ARLEN+1 beats.
REQ-020 R handshake = RVALID & RREADY at an edge; beat counter increments only then; RVALID SHALL NOT drop before a handshake.
REQ-021 At the R handshake of the RLAST beat the FSM SHALL return to IDLE: ARREADY = 1 and RVALID = 0 in the next cycle; no new AR is accepted during DATA.
REQ-022 Backdoor write SHALL update memory at the rising edge when mem_we = 1; if a beat load reads the same word in that edge, it SHALL capture the old data (read-before-write).
REQ-023 Memory contents SHALL NOT be cleared by reset; unwritten words read as X and are not checked.

Reset
REQ-024 While ARESETn = 0: FSM = IDLE, ARREADY = 0, RVALID = 0, RLAST = 0, RID = 0, RDATA = 0, RRESP = 00, beat counter = 0.
REQ-025 ARREADY SHALL go to 1 at the first rising edge after ARESETn deasserts.
REQ-026 Reset asserted mid-burst SHALL abort it immediately; no remaining beats are issued afterwards.

Verification
REQ-027 Preload mem[4..7] = 0xA0..0xA3; AR INCR ARADDR=0x10 ARLEN=3 ARSIZE=2 ARID=1, RREADY=1 -> 4 consecutive beats 0xA0,0xA1,0xA2,0xA3, RID=1, RRESP=00, RLAST on beat 4 only, ARREADY=1 the following cycle.
REQ-028 WRAP ARADDR=0x18 ARLEN=3 ARSIZE=2 -> word addresses 6,7,4,5, i.e. data 0xA2,0xA3,0xA0,0xA1.
REQ-029 FIXED ARADDR=0x10 ARLEN=2 with RREADY toggling 1,0,0,1,1 -> three beats of 0xA0, RDATA/RLAST stable during stalls, exactly 3 handshakes.
REQ-030 ARBURST=11 ARLEN=1 -> 2 beats RRESP=10, RDATA=0; ARADDR=0x400 ARLEN=0 with AddrBits=8 -> 1 beat RRESP=11, RLAST=1.
REQ-031 ARESETn pulsed low during beat 2 of an ARLEN=3 burst -> all outputs take reset values at once, ARREADY=1 one edge after release, no further RVALID.
REQ-032 mem_we to word 4 = 0xBB on the same edge as the AR handshake for ARADDR=0x10 ARLEN=0 -> beat data 0xA0; a second read of the same address returns 0xBB.
